// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - miss request, memory return and array write signals of the fill controller
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
);
  localparam int IW = $clog2(WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [ADDR_W-1:0] memory_data;
  logic              fsm_busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic              write_tag_array;
  logic [IW-1:0]     fill_word;
  logic [ADDR_W-1:0] fill_data;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_rd_en, memory_address,
    output write_data_array, write_tag_array, fill_word, fill_data
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_rd_en, memory_address,
    input  write_data_array, write_tag_array, fill_word, fill_data
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache line fill controller: issues block reads, streams returns into data/tag arrays
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_fsm_if.master  bus
);
  localparam int IW = $clog2(WORDS);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] base, base_d;
  logic [IW:0]       issue_cnt, issue_d;
  logic [IW-1:0]     rcv_cnt, rcv_d;

  logic              busy, rd_en, wr_data, wr_tag;
  logic [ADDR_W-1:0] addr, data, offset;
  logic [IW-1:0]     word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
    end else begin
      state     <= state_d;
      base      <= base_d;
      issue_cnt <= issue_d;
      rcv_cnt   <= rcv_d;
    end
  end

  always_comb begin
    state_d = state;
    base_d  = base;
    issue_d = issue_cnt;
    rcv_d   = rcv_cnt;
    busy    = 1'b0;
    rd_en   = 1'b0;
    addr    = '0;
    offset  = '0;
    wr_data = 1'b0;
    wr_tag  = 1'b0;
    word    = '0;
    data    = '0;
    case (state)
      IDLE: begin
        if (bus.miss_detected) begin
          base_d        = bus.miss_address;
          base_d[IW:0]  = '0;
          issue_d       = '0;
          rcv_d         = '0;
          state_d       = FILL;
        end
      end
      FILL: begin
        busy  = 1'b1;
        rd_en = (issue_cnt < (IW+1)'(WORDS));
        if (rd_en) begin
          // word offset scaled to bytes; base is block aligned so no carry leaves the block
          offset[IW:1] = issue_cnt[IW-1:0];
          addr         = base + offset;
          issue_d      = issue_cnt + (IW+1)'(1);
        end
        wr_data = bus.memory_data_valid;
        word    = rcv_cnt;
        data    = bus.memory_data;
        if (bus.memory_data_valid) begin
          rcv_d = rcv_cnt + IW'(1);
          if (rcv_cnt == IW'(WORDS-1)) begin
            wr_tag  = 1'b1;
            state_d = IDLE;
            issue_d = '0;
            rcv_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fsm_busy         = busy;
  assign bus.mem_rd_en        = rd_en;
  assign bus.memory_address   = addr;
  assign bus.write_data_array = wr_data;
  assign bus.write_tag_array  = wr_tag;
  assign bus.fill_word        = word;
  assign bus.fill_data        = data;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - bench for cache_fill_fsm with a queue-based fill model and in-order memory
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;

  cache_fill_fsm_if #(.ADDR_W(16), .WORDS(8)) bus();
  cache_fill_fsm #(.ADDR_W(16), .WORDS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] salt;

  // reference model: one outstanding fill described by its remaining request list
  bit          m_busy = 1'b0;
  int          m_rcv  = 0;
  logic [15:0] m_base = 16'h0;
  logic [15:0] exp_req[$];
  logic [15:0] pend_data[$];
  int          pend_time[$];
  int          cyc    = 0;
  int          last_t = 0;

  logic [15:0] req_log[$];
  int          n_wr, n_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] memfun(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  task automatic step(input bit miss, input logic [15:0] maddr, input int lat, input int gap, input bit stray);
    bit          v;
    logic [15:0] d;
    bit          e_rd;
    logic [15:0] e_addr;
    int          t;
    @(negedge clk);
    v = 1'b0;
    d = 16'($urandom);
    if (pend_data.size() > 0 && pend_time[0] <= cyc) begin
      v = 1'b1;
      d = pend_data.pop_front();
      void'(pend_time.pop_front());
    end else if (pend_data.size() == 0 && stray) begin
      v = 1'($urandom);
    end
    bus.miss_detected     = miss;
    bus.miss_address      = maddr;
    bus.memory_data_valid = v;
    bus.memory_data       = d;
    #1;
    e_rd   = m_busy && (exp_req.size() > 0);
    e_addr = e_rd ? exp_req[0] : 16'h0;
    chk("busy",      32'(bus.fsm_busy),         32'(m_busy));
    chk("rd_en",     32'(bus.mem_rd_en),        32'(e_rd));
    chk("mem_addr",  32'(bus.memory_address),   32'(e_addr));
    chk("wr_data",   32'(bus.write_data_array), 32'(m_busy && v));
    chk("wr_tag",    32'(bus.write_tag_array),  32'(m_busy && v && m_rcv == 7));
    chk("fill_word", 32'(bus.fill_word),        m_busy ? 32'(m_rcv) : 32'd0);
    chk("fill_data", 32'(bus.fill_data),        m_busy ? 32'(d) : 32'd0);
    if (m_busy && v)
      chk("fill_mem", 32'(bus.fill_data), 32'(memfun(m_base + 16'(2 * m_rcv))));
    if (bus.mem_rd_en === 1'b1) req_log.push_back(bus.memory_address);
    if (bus.write_data_array === 1'b1) n_wr++;
    if (bus.write_tag_array === 1'b1) n_tag++;
    if (e_rd) begin
      t = last_t + 1 + int'($urandom_range(gap));
      if (t < cyc + lat) t = cyc + lat;
      last_t = t;
      pend_data.push_back(memfun(e_addr));
      pend_time.push_back(t);
    end
    if (m_busy) begin
      if (e_rd) void'(exp_req.pop_front());
      if (v) begin
        m_rcv++;
        if (m_rcv == 8) begin
          m_busy = 1'b0;
          m_rcv  = 0;
        end
      end
    end else if (miss) begin
      m_busy = 1'b1;
      m_base = maddr & 16'hFFF0;
      m_rcv  = 0;
      exp_req.delete();
      for (int i = 0; i < 8; i++) exp_req.push_back(m_base + 16'(2 * i));
      last_t = cyc;
    end
    cyc++;
  endtask

  task automatic fill(input logic [15:0] a, input int lat, input int gap, input bit hold_miss,
                      input logic [15:0] a2, input int abort_at);
    int n;
    req_log.delete();
    n_wr  = 0;
    n_tag = 0;
    step(1'b1, a, lat, gap, 1'b0);
    n = 0;
    while (m_busy && n < 200 && !(abort_at > 0 && m_rcv >= abort_at)) begin
      step(hold_miss, hold_miss ? a2 : 16'($urandom), lat, gap, 1'b0);
      n++;
    end
    chk("fill_bound", 32'(n < 200), 32'd1);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      bus.miss_detected     = 1'(i & 1) ^ 1'b1;
      bus.miss_address      = 16'($urandom);
      bus.memory_data_valid = 1'(i & 1);
      bus.memory_data       = 16'($urandom);
      #1;
      chk("rst_busy",  32'(bus.fsm_busy),         32'd0);
      chk("rst_rd",    32'(bus.mem_rd_en),        32'd0);
      chk("rst_addr",  32'(bus.memory_address),   32'd0);
      chk("rst_wd",    32'(bus.write_data_array), 32'd0);
      chk("rst_tag",   32'(bus.write_tag_array),  32'd0);
      chk("rst_word",  32'(bus.fill_word),        32'd0);
      chk("rst_data",  32'(bus.fill_data),        32'd0);
      @(posedge clk);
      #2;
    end
    @(negedge clk);
    rst = 1'b1;
    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b0;
    m_busy = 1'b0;
    m_rcv  = 0;
    exp_req.delete();
    pend_data.delete();
    pend_time.delete();
  endtask

  initial begin
    bit ok;
    salt = 16'($urandom);
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0;

    do_reset(2);
    repeat (4) step(1'b0, 16'($urandom), 1, 0, 1'b1);

    fill(16'h1234, 4, 0, 1'b0, 16'h0, 0);
    chk("basic_nreq",  32'(req_log.size()), 32'd8);
    chk("basic_first", 32'(req_log[0]),     32'h1230);
    chk("basic_last",  32'(req_log[7]),     32'h123E);
    chk("basic_nwr",   32'(n_wr),           32'd8);
    chk("basic_ntag",  32'(n_tag),          32'd1);
    step(1'b0, 16'h0, 1, 0, 1'b1);

    for (int k = 0; k < 3; k++) begin
      fill(16'($urandom), int'($urandom_range(5, 1)), 3, 1'b0, 16'h0, 0);
      chk("irr_nreq", 32'(req_log.size()), 32'd8);
      chk("irr_nwr",  32'(n_wr),           32'd8);
      chk("irr_ntag", 32'(n_tag),          32'd1);
      repeat (2) step(1'b0, 16'($urandom), 1, 0, 1'b1);
    end

    fill(16'hFFFF, 2, 1, 1'b0, 16'h0, 0);
    ok = (req_log.size() == 8);
    foreach (req_log[i]) if (req_log[i][15:4] != 12'hFFF) ok = 1'b0;
    chk("wrap_inblock", 32'(ok),         32'd1);
    chk("wrap_first",   32'(req_log[0]), 32'hFFF0);
    chk("wrap_last",    32'(req_log[7]), 32'hFFFE);

    fill(16'h5678, 3, 2, 1'b1, 16'h0040, 0);
    chk("held_nwr",  32'(n_wr),  32'd8);
    chk("held_ntag", 32'(n_tag), 32'd1);
    fill(16'h0040, 2, 1, 1'b0, 16'h0, 0);
    chk("held_next_first", 32'(req_log[0]), 32'h0040);
    chk("held_next_ntag",  32'(n_tag),      32'd1);

    fill(16'($urandom), 2, 1, 1'b0, 16'h0, 3);
    do_reset(1);
    chk("abort_nwr",  32'(n_wr),  32'd3);
    chk("abort_ntag", 32'(n_tag), 32'd0);
    repeat (2) step(1'b0, 16'($urandom), 1, 0, 1'b1);
    fill(16'h2000, 3, 2, 1'b0, 16'h0, 0);
    chk("after_first", 32'(req_log[0]), 32'h2000);
    chk("after_nwr",   32'(n_wr),       32'd8);
    chk("after_ntag",  32'(n_tag),      32'd1);
    step(1'b0, 16'h0, 1, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Read-side fill controller for the cache data and tag arrays. It drives write enables and data into the arrays' enable-gated storage registers.
- On a miss, it fetches one 16-byte block (8 x 16-bit words) from the multi-cycle main memory. It then streams each returned word into the data array and writes the tag with the last word.
- It sits between cache hit/miss logic and main memory, one instance per cache (I and D).

Parameters:
- ADDR_W, 16, address and data width in bits.
- WORDS, 8, words per block (a power of 2); the word index width is log2(WORDS).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- miss_detected  input  1  cache miss request; sampled only in IDLE.
- miss_address  input  ADDR_W  byte address of the missing access.
- memory_data_valid  input  1  memory returns one word this cycle.
- memory_data  input  ADDR_W  returned memory word.
- fsm_busy  output  1  fill in progress; pipeline stalls while high.
- mem_rd_en  output  1  read request to memory this cycle.
- memory_address  output  ADDR_W  byte address of the current request.
- write_data_array  output  1  data array word write enable.
- write_tag_array  output  1  tag array write enable.
- fill_word  output  3  word index within the block for the current data write.
- fill_data  output  ADDR_W  word to write into the data array.

Behaviour:
- State: two states, IDLE and FILL.
- Registers: state; base (block address, low 4 bits zero); issue_cnt (4 bits, 0..8); rcv_cnt (3 bits, 0..7).
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately.
  - base, issue_cnt and rcv_cnt clear to 0.
  - All outputs read 0 while in reset.
- IDLE:
  - fsm_busy=0, mem_rd_en=0, memory_address=0, write_data_array=0, write_tag_array=0, fill_word=0, fill_data=0.
  - If miss_detected=1 at a clock edge: base <= miss_address with bits [3:0] cleared; issue_cnt <= 0; rcv_cnt <= 0; state <= FILL.
  - memory_data_valid is ignored in IDLE.
- FILL, fsm_busy = 1.
- FILL, issue side:
  - mem_rd_en = (issue_cnt < 8).
  - memory_address = base + 2*issue_cnt[2:0] while mem_rd_en=1, else 0.
  - issue_cnt increments on every FILL cycle while it is below 8, then saturates at 8.
  - One request per cycle, so 8 consecutive requests start on the first FILL cycle.
- FILL, receive side:
  - write_data_array = memory_data_valid.
  - fill_word = rcv_cnt.
  - fill_data = memory_data.
  - rcv_cnt increments on each valid.
- Completion:
  - When memory_data_valid=1 and rcv_cnt=7: write_tag_array=1 in the same cycle.
  - Next state is IDLE; counters clear.
  - fsm_busy falls the cycle after the last data write.
- Latency:
  - Outputs are combinational from registered state plus memory_data_valid/memory_data. There are no added pipeline stages.
  - The block makes no assumption about memory latency. Returns are consumed in order as they arrive, including during issuing.
- Ignored inputs:
  - miss_detected in FILL, including on the completing cycle. A held miss is re-accepted on the first IDLE edge.
  - miss_address changes after acceptance.
- Address arithmetic:
  - The add is ADDR_W bits and wraps modulo 2^16. Base 0xFFF0 issues 0xFFF0..0xFFFE.
  - No carry crosses out of the block, because base[3:0]=0.
- Reset mid-fill: the fill is abandoned and state returns to IDLE. No tag write is produced, and the partially written data lines are left as is (tag not updated, so the line stays invalid).
- Extra returns: a valid beyond 8 returns cannot occur in FILL, because the 8th return ends the fill. A stray valid in IDLE produces no write.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles with all inputs toggling -> all outputs 0; after release with no miss -> outputs stay 0.
- Basic fill, miss_address=0x1234, memory model latency 4:
  - fsm_busy=1 from the next cycle.
  - mem_rd_en=1 for 8 cycles at 0x1230, 0x1232, ..., 0x123E.
  - write_data_array pulses 8 times with fill_word 0..7 and fill_data equal to the memory words.
  - write_tag_array=1 only with fill_word=7; fsm_busy=0 the next cycle.
- Irregular returns: memory inserts 0-3 idle cycles randomly between valids -> still exactly 8 data writes in order 0..7 and one tag write; busy is held throughout.
- Wrap: miss_address=0xFFFF -> addresses 0xFFF0..0xFFFE and no out-of-block address.
- Miss during fill: second miss_detected=1 with address 0x0040, held through the fill -> ignored until IDLE; a new fill then starts at 0x0040 one cycle after busy falls.
- Reset mid-fill: assert rst=0 after the 3rd data write -> outputs 0 immediately, no tag write; a later miss at 0x2000 fills cleanly with fill_word starting at 0.
